// File: rtl/step_mon_pkg.sv
// Shared types, widths and defaults for the load-step response monitor.
// Optional feature macro: STEP_MON_PEAK_EN (peak deviation tracking).
package step_mon_pkg;

    localparam int              CNT_W        = 16;
    localparam int              ADC_W        = 12;
    localparam logic [CNT_W-1:0] TMAX_DEF    = 16'd4000;  // 20 ms at the monitor clock
    localparam int              SETTLE_N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // |a - b| via a 13-bit signed difference, truncated back to the ADC width
    function automatic logic [ADC_W-1:0] abs_dev(input logic [ADC_W-1:0] a,
                                                 input logic [ADC_W-1:0] b);
        logic signed [ADC_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[ADC_W] ? ADC_W'(-d) : ADC_W'(d);
    endfunction

endpackage

// File: rtl/step_edge_det.sv
// Registers the load-step control once and flags any change of level.
// The polarity output is the new level, i.e. 1 for a rising (load applied) step.
module step_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic step_edge,
    output logic step_pol
);

    logic step_d;

    // Delayed copy of step; reset also loads the live level so no edge
    // is seen on the first cycle after reset.
    always_ff @(posedge clk) begin
        step_d <= step;
    end

    assign step_edge = step ^ step_d;
    assign step_pol  = step;

endmodule

// File: rtl/step_resp_mon.sv
// Load-step response monitor: on a step edge, measures how long Vout takes
// to stay inside vref +/- tol for SETTLE_N consecutive samples, with a TMAX
// cycle timeout. Optional peak deviation capture under STEP_MON_PEAK_EN.
module step_resp_mon
    import step_mon_pkg::*;
#(
    parameter logic [CNT_W-1:0] TMAX     = TMAX_DEF,
    parameter int               SETTLE_N = SETTLE_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             step,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [ADC_W-1:0] vref,
    input  logic [ADC_W-1:0] tol,
    output logic [CNT_W-1:0] settle_time,
    output logic [ADC_W-1:0] peak_dev,
    output logic             step_dir,
    output logic             timeout,
    output logic             result_valid,
    output logic             overrun
);

    state_t           state_q, state_n;
    logic             step_edge, step_pol;
    // cyc holds the index of the current MEASURE cycle (1 on the first one)
    logic [CNT_W-1:0] cyc, run_cnt, last_out, run_inc;
    logic             dir_lat;
    logic             sample, in_band, settle, tmo, restart, finish;
    logic [ADC_W-1:0] dev;

    step_edge_det u_edge (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .step_edge (step_edge),
        .step_pol  (step_pol)
    );

    // Per-cycle measurement decisions
    always_comb begin
        sample  = (state_q == MEASURE) && adc_valid;
        dev     = abs_dev(adc_data, vref);
        in_band = (dev <= tol);
        run_inc = run_cnt + CNT_W'(1);
        settle  = sample && in_band && (run_inc == CNT_W'(SETTLE_N));
        tmo     = (state_q == MEASURE) && (cyc == TMAX) && !settle;
        // an edge in ARMED starts, an edge in MEASURE restarts
        restart = enable && step_edge && (state_q == ARMED || state_q == MEASURE);
        finish  = enable && !step_edge && (state_q == MEASURE) && (settle || tmo);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    // Next-state logic; dropping enable always aborts to IDLE
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_n = ARMED;
            ARMED:   if (!enable) state_n = IDLE;
                     else if (restart) state_n = MEASURE;
            MEASURE: if (!enable) state_n = IDLE;
                     else if (finish) state_n = DONE;
            DONE:    state_n = enable ? ARMED : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        result_valid = (state_q == DONE);
    end

    // Counters, in-band run tracking and the held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc         <= '0;
            run_cnt     <= '0;
            last_out    <= '0;
            dir_lat     <= 1'b0;
            settle_time <= '0;
            step_dir    <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (restart) begin
                cyc      <= CNT_W'(1);
                run_cnt  <= '0;
                last_out <= '0;
                dir_lat  <= step_pol;
                if (state_q == MEASURE) overrun <= 1'b1;
            end else if (state_q == MEASURE) begin
                if (cyc != TMAX) cyc <= cyc + CNT_W'(1);
                if (sample) begin
                    if (in_band) begin
                        run_cnt <= run_inc;
                    end else begin
                        run_cnt  <= '0;
                        last_out <= cyc;
                    end
                end
            end
            if (finish) begin
                settle_time <= settle ? last_out : TMAX;
                timeout     <= !settle;
                step_dir    <= dir_lat;
            end
        end
    end

`ifdef STEP_MON_PEAK_EN
    logic [ADC_W-1:0] peak, peak_nxt;

    // Running maximum including the current sample, so the final sample counts
    always_comb begin
        peak_nxt = (sample && dev > peak) ? dev : peak;
    end

    // Peak tracker and its held result copy
    always_ff @(posedge clk) begin
        if (rst) begin
            peak     <= '0;
            peak_dev <= '0;
        end else begin
            if (restart)                   peak <= '0;
            else if (state_q == MEASURE)   peak <= peak_nxt;
            if (finish)                    peak_dev <= peak_nxt;
        end
    end
`else
    assign peak_dev = '0;
`endif

endmodule

// File: doc/step_resp_mon.md
STEP_RESP_MON -- requirements
Module: step_resp_mon

Interface
REQ-001 Parameter: TMAX, default 16'd4000 (20 ms), measurement timeout in clk cycles.
REQ-002 Parameter: SETTLE_N, default 8, consecutive in-band ADC samples that declare settling.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 enable  input  1  arms the monitor.
REQ-006 step  input  1  load-step control from step_gen output c0.
REQ-007 adc_valid  input  1  single-cycle strobe qualifying adc_data.
REQ-008 adc_data  input  12  unsigned Vout sample.
REQ-009 vref  input  12  unsigned regulation target.
REQ-010 tol  input  12  unsigned allowed |Vout - vref| band.
REQ-011 settle_time  output  16  cycles from step edge to settling.
REQ-012 peak_dev  output  12  maximum |Vout - vref| seen during the measurement.
REQ-013 step_dir  output  1  1 = rising step (load applied), 0 = falling.
REQ-014 timeout  output  1  measurement ended at TMAX without settling.
REQ-015 result_valid  output  1  one-cycle pulse; result outputs are valid and held until the next result.
REQ-016 overrun  output  1  sticky: a step edge arrived while MEASURE was in progress.

Function
REQ-017 step is registered once (step_d); an edge is step != step_d, and step_dir takes the value of step at the edge.
REQ-018 FSM states are IDLE, ARMED, MEASURE and DONE.
- IDLE -> ARMED when enable=1.
- ARMED -> MEASURE on an edge.
- MEASURE -> DONE on settle or timeout.
- DONE -> ARMED if enable=1, else IDLE; DONE lasts exactly one cycle.
REQ-019 On entry to MEASURE, clear cyc, run_cnt, last_out and peak.
REQ-020 In MEASURE, cyc increments every cycle starting from 1 on the first MEASURE cycle, and saturates at TMAX.
REQ-021 On an adc_valid sample, dev = |adc_data - vref| is computed with a 13-bit signed difference and the absolute value truncated to 12 bits.
REQ-022 If dev <= tol, run_cnt increments; otherwise run_cnt is cleared and last_out = cyc.
REQ-023 Settle occurs when run_cnt reaches SETTLE_N; then settle_time = last_out (0 if no sample was ever out of band) and timeout = 0.
REQ-024 Timeout occurs when cyc == TMAX with no settle; then settle_time = TMAX and timeout = 1.
REQ-025 If settle and timeout occur in the same cycle, settle wins.
REQ-026 result_valid = 1 exactly in the DONE cycle; settle_time, peak_dev, step_dir and timeout update in the same cycle and then hold.
REQ-027 An edge during MEASURE sets overrun, restarts the measurement (REQ-019), and latches the new step_dir.
REQ-028 An edge in IDLE or DONE is ignored.
REQ-029 enable=0 during ARMED or MEASURE moves the FSM to IDLE with no result_valid and outputs unchanged.
REQ-030 adc_valid is ignored outside MEASURE.

Reset
REQ-031 rst=1 sets the FSM to IDLE and clears every output, cyc, run_cnt, last_out and peak.
REQ-032 rst=1 loads step_d with the current step, so no spurious edge is detected after reset.
REQ-033 rst mid-MEASURE discards the measurement with no result_valid.

Configuration
REQ-034 Macro STEP_MON_PEAK_EN.
- Defined: peak = max(peak, dev) on each in-MEASURE sample, and peak_dev is loaded from peak in DONE.
- Undefined: the peak logic is absent and peak_dev is tied to 0.

Structure
REQ-035 Package step_mon_pkg holds the FSM state enum, CNT_W=16, ADC_W=12, and the defaults for TMAX and SETTLE_N.
REQ-036 One sub-module, step_edge_det, provides the registered step, the edge strobe and the polarity.
REQ-037 Everything else is in a single module.

Verification
REQ-038 Settled response: vref=2048, tol=20, SETTLE_N=8, rising step, samples every 10 cycles of 2200, 2150, 2100, then 2050 repeated -> settle_time=30, peak_dev=152, step_dir=1, timeout=0, one result_valid.
REQ-039 No deviation: falling step, all samples 2048 -> settle_time=0, settles on the 8th sample, step_dir=0.
REQ-040 Timeout: samples held at 2300 with TMAX=4000 -> result_valid at cyc 4000, timeout=1, settle_time=4000.
REQ-041 Overrun: second edge at cyc 500 -> overrun=1, cyc restarts from 1, and the result is for the second edge only.
REQ-042 Aborted measurement: enable dropped in MEASURE, or rst asserted at cyc 100 -> IDLE, no result_valid, outputs unchanged (enable case) or all 0 (rst case).
REQ-043 Peak macro: repeat REQ-038 with STEP_MON_PEAK_EN undefined -> peak_dev=0 and all other outputs unchanged.
